// File: rtl/add_num_result_writer_if.sv
// Bus bundle between the add-two-numbers read stage, the result writer and
// the CCI-P c1 TX/RX channel.
//
// Handshakes:
//   line_valid/line_ready : a line is consumed on the clock edge where both
//                           are high. The upstream holds line_valid,
//                           line_data and wr_addr stable until that edge.
//   c1_req_valid          : one-cycle write request. It is only raised while
//                           c1_alm_full was low at the issuing edge.
//                           There is no ready signal, because the almost-full
//                           flag is the flow control.
//   c1_rsp_valid          : one-cycle write acknowledge. It is meaningful only
//                           while a request is outstanding.
interface add_num_result_writer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 42
);
  logic                  line_valid;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  c1_alm_full;
  logic                  c1_req_valid;
  logic [ADDR_WIDTH-1:0] c1_req_addr;
  logic                  c1_req_sop;
  logic [DATA_WIDTH-1:0] c1_req_data;
  logic                  c1_rsp_valid;

  // Writer side: consumes lines, issues c1 writes.
  modport master (
    input  line_valid, line_data, wr_addr, c1_alm_full, c1_rsp_valid,
    output line_ready, c1_req_valid, c1_req_addr, c1_req_sop, c1_req_data
  );

  // Environment side: read stage plus CCI-P channel.
  modport slave (
    output line_valid, line_data, wr_addr, c1_alm_full, c1_rsp_valid,
    input  line_ready, c1_req_valid, c1_req_addr, c1_req_sop, c1_req_data
  );
endinterface

// File: rtl/add_num_result_writer.sv
// Result writer for the add-two-numbers AFU.
// This block takes an operand line, adds operands A and B, and writes the
// sum as a single-beat c1 line write. It then waits for the write ack,
// and reports completion or a sticky timeout.
module add_num_result_writer #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 42,
  parameter int OPERAND_WIDTH  = 8,
  parameter int A_LSB          = 8,
  parameter int B_LSB          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  add_num_result_writer_if.master bus,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] done_count,
  output logic        err_timeout,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPUTE  = 3'd1,
    REQ      = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e state, state_next;

  logic [OPERAND_WIDTH-1:0] a_q, b_q;
  logic [ADDR_WIDTH-1:0]    dest_q;
  logic [CNT_W-1:0]         wait_cnt;
  logic [OPERAND_WIDTH:0]   sum;

  // FSM strobes produced by the next-state logic
  logic accept, load_req, issue, finish, expire;

  assign sum            = {1'b0, a_q} + {1'b0, b_q};
  assign bus.line_ready = (state == IDLE);
  assign state_dbg      = state;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_req   = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.line_valid) begin
          accept     = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        load_req   = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (!bus.c1_alm_full) begin
          issue      = 1'b1;
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the expiry cycle still counts as success.
        if (bus.c1_rsp_valid) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture operands and destination when a line is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      dest_q <= '0;
    end else if (accept) begin
      a_q    <= bus.line_data[A_LSB +: OPERAND_WIDTH];
      b_q    <= bus.line_data[B_LSB +: OPERAND_WIDTH];
      dest_q <= bus.wr_addr;
    end
  end

  // Write request: payload loaded in COMPUTE and held until the next load.
  // The valid/sop signals are one-cycle strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.c1_req_valid <= 1'b0;
      bus.c1_req_sop   <= 1'b0;
      bus.c1_req_addr  <= '0;
      bus.c1_req_data  <= '0;
    end else begin
      bus.c1_req_valid <= issue;
      bus.c1_req_sop   <= issue;
      if (load_req) begin
        bus.c1_req_addr <= dest_q;
        bus.c1_req_data <= DATA_WIDTH'(sum);
      end
    end
  end

  // Response wait counter, restarted every time WAIT_RSP is entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wait_cnt <= '0;
    else if (state != WAIT_RSP)  wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end

  // Status outputs: busy, completion strobe, wrapping count, sticky timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      done_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      done_pulse <= finish;
      if (finish) done_count  <= done_count + 16'd1;
      if (expire) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_add_num_result_writer.sv
// Bench for add_num_result_writer: directed corner cases plus random
// transactions, checked against a sum/address/count model of the writer.
module tb_add_num_result_writer;

  localparam int DW      = 512;
  localparam int AW      = 42;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 16;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset_n;
  logic        busy;
  logic        done_pulse;
  logic [15:0] done_count;
  logic        err_timeout;
  logic [2:0]  state_dbg;

  add_num_result_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  add_num_result_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPERAND_WIDTH(8),
    .A_LSB(A_LSB), .B_LSB(B_LSB), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .busy(busy), .done_pulse(done_pulse), .done_count(done_count),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_req_exp = 0, n_req_seen = 0;
  int            n_done_exp = 0, n_done_seen = 0;
  logic [15:0]   exp_count = 16'd0;
  logic          exp_err   = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every issued write is matched against the oldest expected one
  always @(negedge clk) begin
    if (reset_n && bus.c1_req_valid) begin
      n_req_seen++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_req", 1, 0);
      end else begin
        check_eq("req_data", bus.c1_req_data, exp_q.pop_front());
        check_eq("req_addr", DW'(bus.c1_req_addr), DW'(exp_addr_q.pop_front()));
        check_eq("req_sop", bus.c1_req_sop, 1);
      end
    end
    if (reset_n && done_pulse) n_done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req_valid"}, bus.c1_req_valid, 0);
    check_eq({tag, "_req_sop"},   bus.c1_req_sop, 0);
    check_eq({tag, "_req_addr"},  DW'(bus.c1_req_addr), 0);
    check_eq({tag, "_req_data"},  bus.c1_req_data, 0);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_done"},      done_pulse, 0);
    check_eq({tag, "_count"},     DW'(done_count), 0);
    check_eq({tag, "_err"},       err_timeout, 0);
    check_eq({tag, "_ready"},     bus.line_ready, 1);
  endtask

  // Present a line, model its result, then run until the write request appears.
  // The bench holds alm_full high for `stall` REQ edges.
  task automatic start_and_issue(input logic [7:0] a, input logic [7:0] b,
                                 input logic [AW-1:0] addr, input int stall,
                                 input bit hold_valid, output bit ok);
    logic [DW-1:0] line;
    int k;
    bit seen;
    for (int i = 0; i < DW / 32; i++) line[i*32 +: 32] = $urandom;
    line[A_LSB +: 8] = a;
    line[B_LSB +: 8] = b;
    @(negedge clk);
    bus.line_valid  = 1'b1;
    bus.line_data   = line;
    bus.wr_addr     = addr;
    bus.c1_alm_full = (stall > 0);
    check_eq("line_ready_idle", bus.line_ready, 1);
    exp_q.push_back(DW'(int'(a) + int'(b)));
    exp_addr_q.push_back(addr);
    n_req_exp++;
    @(posedge clk); #1;
    if (!hold_valid) bus.line_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    check_eq("ready_after_accept", bus.line_ready, 0);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 64) begin
      k++;
      bus.c1_alm_full = (stall > 0) && (k < 2 + stall);
      @(posedge clk); #1;
      if (bus.c1_req_valid) seen = 1'b1;
    end
    bus.c1_alm_full = 1'b0;
    if (!seen) check_eq("req_seen", 0, 1);
    else       check_eq("req_latency", k, 2 + stall);
    ok = seen;
  endtask

  // A full transaction. rsp_dly is the WAIT_RSP cycle index carrying the ack.
  // A negative value means no ack, so the transaction times out.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [AW-1:0] addr, input int stall,
                         input int rsp_dly, input bit hold_valid);
    bit ok;
    start_and_issue(a, b, addr, stall, hold_valid, ok);
    if (!ok) return;
    for (int d = 0; d < TIMEOUT; d++) begin
      bus.c1_rsp_valid = (d == rsp_dly);
      @(posedge clk); #1;
      bus.c1_rsp_valid = 1'b0;
      if (d == rsp_dly) begin
        exp_count++;
        n_done_exp++;
        check_eq("done_pulse", done_pulse, 1);
        check_eq("done_count", DW'(done_count), DW'(exp_count));
        check_eq("err_on_done", err_timeout, exp_err);
        check_eq("ready_in_done", bus.line_ready, 0);
        @(posedge clk); #1;
        check_eq("done_pulse_len", done_pulse, 0);
        check_eq("busy_after_done", busy, 0);
        check_eq("ready_after_done", bus.line_ready, 1);
        return;
      end
      if (d == TIMEOUT - 2) begin
        check_eq("err_before_expiry", err_timeout, exp_err);
        check_eq("busy_before_expiry", busy, 1);
      end
      if (d == TIMEOUT - 1) begin
        exp_err = 1'b1;
        check_eq("err_timeout", err_timeout, 1);
        check_eq("busy_after_timeout", busy, 0);
        check_eq("no_done_on_timeout", done_pulse, 0);
        check_eq("count_on_timeout", DW'(done_count), DW'(exp_count));
        check_eq("ready_after_timeout", bus.line_ready, 1);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    reset_n          = 1'b0;
    bus.line_valid   = 1'b0;
    bus.line_data    = '0;
    bus.wr_addr      = '0;
    bus.c1_alm_full  = 1'b0;
    bus.c1_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset");

    // basic add, carry, backpressure
    run_txn(8'h23, 8'h45, 42'h1000, 0, 3, 1'b0);
    run_txn(8'hFF, 8'hFF, 42'h2040, 0, 0, 1'b0);
    run_txn(8'h10, 8'h01, 42'h0ABC, 5, 2, 1'b0);

    // line_valid held through a whole transaction, then a second line
    run_txn(8'h7F, 8'h01, 42'h3000, 0, 1, 1'b1);
    run_txn(8'h80, 8'h80, 42'h3001, 1, 4, 1'b0);

    // ack in the same cycle the timeout would expire
    run_txn(8'h05, 8'h06, 42'h4000, 0, TIMEOUT - 1, 1'b0);

    // random traffic
    for (int t = 0; t < 10; t++) begin
      run_txn(8'($urandom), 8'($urandom), AW'({$urandom, $urandom}),
              $urandom_range(0, 3), $urandom_range(0, 10), 1'b0);
    end

    // timeout, then a later transaction still completes with the error kept
    run_txn(8'h11, 8'h22, 42'h5000, 0, -1, 1'b0);
    run_txn(8'h33, 8'h44, 42'h5001, 2, 5, 1'b0);

    // reset asserted while waiting for the ack, late ack afterwards
    start_and_issue(8'h9A, 8'hBC, 42'h6000, 0, 1'b0, ok);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    exp_count = 16'd0;
    exp_err   = 1'b0;
    @(negedge clk) bus.c1_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bus.c1_rsp_valid = 1'b0;
    check_reset_values("late_ack");
    repeat (2) @(posedge clk);

    // final scoreboard reconciliation
    check_eq("exp_q_empty", DW'(exp_q.size()), 0);
    check_eq("req_total", DW'(n_req_seen), DW'(n_req_exp));
    check_eq("done_total", DW'(n_done_seen), DW'(n_done_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
